// File: rtl/alu_share_pkg.sv
// Shared FSM state type and ALU / bonus control encodings for the ALU-sharing sequencer.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1111;

    localparam logic [2:0] BC_SLT = 3'd0;
    localparam logic [2:0] BC_SGT = 3'd1;
    localparam logic [2:0] BC_SLE = 3'd2;
    localparam logic [2:0] BC_SGE = 3'd3;
    localparam logic [2:0] BC_SEQ = 3'd4;
    localparam logic [2:0] BC_SNE = 3'd5;

    // Wide enough for MUL_CYCLES up to 7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin grant: the requester that did not win last time takes a tie.
module rr_arb2 (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_id_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    always_comb begin
        gnt_valid_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) begin
            gnt_id_o = ~last_id_i;
        end else begin
            gnt_id_o = valid1_i;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external 32-bit ALU between two requesters, one transaction in flight.
// Macro ALU_SHARE_MUL_EN enables multiply with an EXEC hold; otherwise multiply returns err.
//
// state | meaning
// IDLE  | waiting for a request; grant visible on reqN_ready_o
// ISSUE | ALU evaluating registered operands; capture unless multiply
// EXEC  | multiply hold, down-counter to terminal count then capture
// RESP  | response valid, held until resp_ready_i
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              req0_valid_i,
    input  logic              req1_valid_i,
    output logic              req0_ready_o,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,
    input  logic [3:0]        req0_ctrl_i,
    input  logic [3:0]        req1_ctrl_i,
    input  logic [2:0]        req0_bonus_i,
    input  logic [2:0]        req1_bonus_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [3:0]        alu_ctrl_o,
    output logic [2:0]        alu_bonus_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic              alu_cout_i,
    input  logic              alu_overflow_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_id_o,
    output logic [DATA_W-1:0] resp_result_o,
    output logic              resp_zero_o,
    output logic              resp_cout_o,
    output logic              resp_ovf_o,
    output logic              resp_err_o
);

`ifdef ALU_SHARE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MUL_CYCLES - 2);

    state_t            state_q;
    logic              last_id_q;
    logic              id_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic [3:0]        ctrl_q;
    logic [2:0]        bonus_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              cout_q;
    logic              ovf_q;
    logic              err_q;

    logic              gnt_valid;
    logic              gnt_id;
    logic              grant_open;
    logic [DATA_W-1:0] sel_src1;
    logic [DATA_W-1:0] sel_src2;
    logic [3:0]        sel_ctrl;
    logic [2:0]        sel_bonus;

    rr_arb2 u_arb (
        .valid0_i    (req0_valid_i),
        .valid1_i    (req1_valid_i),
        .last_id_i   (last_id_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // Ready is forced low while reset is held so no handshake is advertised.
    assign grant_open   = rst_n && (state_q == IDLE) && gnt_valid;
    assign req0_ready_o = grant_open && !gnt_id;
    assign req1_ready_o = grant_open && gnt_id;

    assign sel_src1  = gnt_id ? req1_src1_i  : req0_src1_i;
    assign sel_src2  = gnt_id ? req1_src2_i  : req0_src2_i;
    assign sel_ctrl  = gnt_id ? req1_ctrl_i  : req0_ctrl_i;
    assign sel_bonus = gnt_id ? req1_bonus_i : req0_bonus_i;

    assign alu_src1_o    = src1_q;
    assign alu_src2_o    = src2_q;
    assign alu_ctrl_o    = ctrl_q;
    assign alu_bonus_o   = bonus_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_id_o     = id_q;
    assign resp_result_o = result_q;
    assign resp_zero_o   = zero_q;
    assign resp_cout_o   = cout_q;
    assign resp_ovf_o    = ovf_q;
    assign resp_err_o    = err_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_id_q    <= 1'b1;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            ctrl_q       <= '0;
            bonus_q      <= '0;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        last_id_q <= gnt_id;
                        id_q      <= gnt_id;
                        // Unsupported multiply bypasses the ALU and leaves its inputs untouched.
                        if (!MUL_EN && sel_ctrl == ALU_MUL) begin
                            result_q     <= '0;
                            zero_q       <= 1'b0;
                            cout_q       <= 1'b0;
                            ovf_q        <= 1'b0;
                            err_q        <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            src1_q  <= sel_src1;
                            src2_q  <= sel_src2;
                            ctrl_q  <= sel_ctrl;
                            bonus_q <= sel_bonus;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (MUL_EN && ctrl_q == ALU_MUL) begin
                        cnt_q   <= HOLD_LOAD;
                        state_q <= EXEC;
                    end else begin
                        result_q     <= alu_result_i;
                        zero_q       <= alu_zero_i;
                        cout_q       <= alu_cout_i;
                        ovf_q        <= alu_overflow_i;
                        err_q        <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        result_q     <= alu_result_i;
                        zero_q       <= alu_zero_i;
                        cout_q       <= alu_cout_i;
                        ovf_q        <= alu_overflow_i;
                        err_q        <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
